multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Sequencing FSM for the multi-cycle MIPS datapath, replacing single-cycle decode: one instruction executes over 3–5 states, sharing one ALU and one unified instruction/data memory. Decodes opcode/funct, drives all datapath mux selects and write enables per state, handshakes with memory via `mem_req`/`mem_ready`, and aborts stalled accesses after a programmable wait limit.

## Interface
- `WAIT_LIMIT`, 255: max cycles a memory access waits for `mem_ready`; 0 = wait forever
- `clk` in 1: clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `opcode` in 6: IR[31:26], valid from DECODE onward
- `funct` in 6: IR[5:0]
- `zero` in 1: ALU zero flag, same cycle
- `mem_ready` in 1: memory accepts/returns current access this cycle
- `mem_req` out 1: memory access active
- `IorD` out 1: address = PC (0) or ALUOut (1)
- `MemWrite` out 1: write memory
- `IRWrite` out 1: load IR
- `pc_en` out 1: load PC
- `PCSrc` out 2: 00 ALU result, 01 ALUOut (branch target), 10 jump target
- `ALUSrcA` out 1: PC (0) or register A (1)
- `ALUSrcB` out 2: 00 reg B, 01 const 4, 10 extended imm, 11 sign-ext imm<<2
- `ext_zero` out 1: immediate zero-extended (1) or sign-extended (0)
- `ALUControl` out 3: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 LUI (B<<16)
- `RegDst` out 1: write address rt (0) / rd (1)
- `MemtoReg` out 1: write data ALUOut (0) / memory data (1)
- `RegWrite` out 1: write register file
- `instr_done` out 1: one-cycle pulse on instruction retirement
- `illegal` out 1: one-cycle pulse, unsupported opcode/funct
- `bus_error` out 1: one-cycle pulse, memory wait limit hit
- `state` out 4: current state, debug

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, IEXEC 9, IWB 10, JUMP 11. Codes 12–15 go to FETCH next cycle.
- All outputs default 0 (`ALUControl` 010); states assert only as listed.
- FETCH: mem_req, IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00; when mem_ready: IRWrite=1, pc_en=1, -> DECODE; else stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ADD. Next: LW 100011/SW 101011 -> MEMADR; R-type 000000 -> EXECUTE; BEQ 000100 -> BRANCH; ADDIU 001001/ORI 001101/LUI 001111 -> IEXEC; J 000010 -> JUMP; other -> illegal=1, -> FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. LW -> MEMRD, SW -> MEMWR.
- MEMRD: mem_req, IorD=1; mem_ready -> MEMWB.
- MEMWB: MemtoReg=1, RegDst=0, RegWrite=1, instr_done=1 -> FETCH.
- MEMWR: mem_req, IorD=1, MemWrite=1; mem_ready -> instr_done=1, -> FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00; funct 100000/100001 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT -> ALUWB; other funct -> illegal=1, -> FETCH.
- ALUWB: RegDst=1, RegWrite=1, instr_done=1, ALUControl held from funct -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, pc_en=zero, instr_done=1 -> FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10; ADDIU ADD, ORI OR with ext_zero=1, LUI LUI -> IWB. IWB: same ALU controls held, RegDst=0, RegWrite=1, instr_done=1 -> FETCH.
- JUMP: PCSrc=10, pc_en=1, instr_done=1 -> FETCH.
- Wait counter (8+ bits, sized to WAIT_LIMIT): cleared on entering FETCH/MEMRD/MEMWR and whenever mem_ready=1; increments each waiting cycle. Counter reaching WAIT_LIMIT without mem_ready: bus_error=1, no IRWrite/pc_en/MemWrite that cycle beyond already asserted mem_req, -> FETCH. mem_ready in the limit cycle wins (normal completion).

## Timing
- Reset: state=FETCH, wait counter=0; first cycle after reset drives FETCH outputs (mem_req=1, all pulses 0).
- rst has priority over every transition, including mid-wait and mid-instruction; no write enables asserted in the reset cycle's next state beyond FETCH values.
- Outputs combinational from state (plus mem_ready, zero, opcode, funct where stated); transitions registered.
- Zero-wait CPI: LW 5, SW 4, R-type 4, I-type 4, BEQ 3, J 3; each waited memory cycle adds 1.
- opcode/funct sampled only in DECODE/MEMADR/EXECUTE/IEXEC/IWB/ALUWB; IR stable since IRWrite only in FETCH.

## Test plan
- Reset mid-MEMRD wait -> next cycle state=0, mem_req=1, IorD=0, no RegWrite.
- ADDU (op 0, funct 100001), mem_ready always 1 -> states 0,1,6,7; RegWrite/RegDst=1 in cycle 4; instr_done once.
- LW with mem_ready low 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4; MemtoReg=1, RegWrite=1 at state 4; CPI 8.
- BEQ with zero=1 then zero=0 -> pc_en=1 with PCSrc=01 in state 8 first case, pc_en=0 second; 3 cycles each.
- Opcode 111111 -> illegal pulse in DECODE, back to FETCH, no RegWrite/MemWrite; R-type funct 000111 -> illegal in EXECUTE.
- WAIT_LIMIT=4, mem_ready held 0 in FETCH -> bus_error on 5th FETCH cycle, IRWrite never 1, FETCH re-entered with counter cleared.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
//
// Bundles every signal between the multi-cycle sequencer and its datapath /
// unified memory. Clock and reset stay outside as plain ports of the users.
//
// Handshake: the memory owns mem_ready. While mem_req is high the access is
// pending; the cycle in which mem_req and mem_ready are both high completes
// the access (instruction or data returned / write accepted). mem_req stays
// high and unchanged for as long as the access is pending.
//
// Modports:
//   master : the controller (drives control, reads IR fields/flags/ready)
//   slave  : the datapath + memory side (drives IR fields/flags/ready)
//
// Signals:
//   opcode[5:0], funct[5:0] : IR fields
//   zero                    : ALU zero flag
//   mem_ready               : memory completes the current access
//   mem_req, IorD, MemWrite : memory access control
//   IRWrite, pc_en, PCSrc   : IR / PC update control
//   ALUSrcA, ALUSrcB, ext_zero, ALUControl : ALU operand / operation select
//   RegDst, MemtoReg, RegWrite : register file write control
//   instr_done, illegal, bus_error : one-cycle status pulses
//   state[3:0]              : current controller state, for debug
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       pc_en;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ext_zero;
    logic [2:0] ALUControl;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       instr_done;
    logic       illegal;
    logic       bus_error;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, IorD, MemWrite, IRWrite, pc_en, PCSrc,
               ALUSrcA, ALUSrcB, ext_zero, ALUControl,
               RegDst, MemtoReg, RegWrite,
               instr_done, illegal, bus_error, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, IorD, MemWrite, IRWrite, pc_en, PCSrc,
               ALUSrcA, ALUSrcB, ext_zero, ALUControl,
               RegDst, MemtoReg, RegWrite,
               instr_done, illegal, bus_error, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Sequencing FSM for a multi-cycle MIPS datapath with one shared ALU and one
// unified instruction/data memory. Each instruction walks through 3..5 states;
// every waited memory cycle adds one more. Memory accesses that wait longer
// than WAIT_LIMIT cycles are abandoned with a bus_error pulse and the machine
// restarts at FETCH.
//
// Parameters:
//   WAIT_LIMIT : max cycles an access waits for mem_ready (0 = wait forever)
//
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : multicycle_controller_if.master (IR fields, flags, memory
//          handshake, all datapath controls, status pulses, debug state)
//
// Outputs are combinational from the state register (plus mem_ready, zero,
// opcode and funct where the state needs them); transitions are registered.
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    multicycle_controller_if.master        bus
);

    // Counter is at least 8 bits and wide enough to hold WAIT_LIMIT.
    localparam int CW_RAW = $clog2(WAIT_LIMIT + 1);
    localparam int CW     = (CW_RAW > 8) ? CW_RAW : 8;
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);
    localparam bit LIMIT_ON = (WAIT_LIMIT != 0);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IEXEC   = 4'd9,
        S_IWB     = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // R-type funct -> ALU operation; valid flag separates unsupported functs.
    function automatic logic funct_ok(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100001, 6'b100010,
            6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
            default:                         funct_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu = ALU_ADD;
        endcase
    endfunction

    // I-type opcode -> ALU operation (only reached for ADDIU/ORI/LUI).
    function automatic logic [2:0] imm_alu(input logic [5:0] op);
        case (op)
            OP_ORI:  imm_alu = ALU_OR;
            OP_LUI:  imm_alu = ALU_LUI;
            default: imm_alu = ALU_ADD;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          timeout;

    // Limit reached and memory still silent; mem_ready in this cycle wins.
    assign timeout = LIMIT_ON && (wait_q == LIMIT) && !bus.mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.state = state_q;

    always_comb begin
        state_d        = state_q;
        // Counter clears on every transition and on mem_ready; only a
        // waiting memory state overrides this with an increment.
        wait_d         = '0;
        bus.mem_req    = 1'b0;
        bus.IorD       = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.pc_en      = 1'b0;
        bus.PCSrc      = 2'b00;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ext_zero   = 1'b0;
        bus.ALUControl = ALU_ADD;
        bus.RegDst     = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.instr_done = 1'b0;
        bus.illegal    = 1'b0;
        bus.bus_error  = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC + 4 computed while the instruction is fetched.
                bus.mem_req = 1'b1;
                bus.ALUSrcB = 2'b01;
                if (bus.mem_ready) begin
                    bus.IRWrite = 1'b1;
                    bus.pc_en   = 1'b1;
                    state_d     = S_DECODE;
                end else if (timeout) begin
                    bus.bus_error = 1'b1;
                    state_d       = S_FETCH;
                end else if (LIMIT_ON) begin
                    wait_d = wait_q + CW'(1);
                end
            end

            S_DECODE: begin
                // Speculative branch target: PC + (sign-ext imm << 2).
                bus.ALUSrcB = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW:               state_d = S_MEMADR;
                    OP_RTYPE:                   state_d = S_EXECUTE;
                    OP_BEQ:                     state_d = S_BRANCH;
                    OP_ADDIU, OP_ORI, OP_LUI:   state_d = S_IEXEC;
                    OP_J:                       state_d = S_JUMP;
                    default: begin
                        bus.illegal = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                if (bus.opcode == OP_SW)
                    state_d = S_MEMWR;
                else if (bus.opcode == OP_LW)
                    state_d = S_MEMRD;
                else
                    state_d = S_FETCH;
            end

            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    bus.bus_error = 1'b1;
                    state_d       = S_FETCH;
                end else if (LIMIT_ON) begin
                    wait_d = wait_q + CW'(1);
                end
            end

            S_MEMWB: begin
                bus.MemtoReg   = 1'b1;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end

            S_MEMWR: begin
                bus.mem_req = 1'b1;
                bus.IorD    = 1'b1;
                // An abandoned store must not look like a write to memory.
                bus.MemWrite = !timeout;
                if (bus.mem_ready) begin
                    bus.instr_done = 1'b1;
                    state_d        = S_FETCH;
                end else if (timeout) begin
                    bus.bus_error = 1'b1;
                    state_d       = S_FETCH;
                end else if (LIMIT_ON) begin
                    wait_d = wait_q + CW'(1);
                end
            end

            S_EXECUTE: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = funct_alu(bus.funct);
                if (funct_ok(bus.funct)) begin
                    state_d = S_ALUWB;
                end else begin
                    bus.illegal = 1'b1;
                    state_d     = S_FETCH;
                end
            end

            S_ALUWB: begin
                // ALU controls kept so the result stays valid through the write.
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = funct_alu(bus.funct);
                bus.RegDst     = 1'b1;
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end

            S_BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = ALU_SUB;
                bus.PCSrc      = 2'b01;
                bus.pc_en      = bus.zero;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end

            S_IEXEC: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.ALUControl = imm_alu(bus.opcode);
                bus.ext_zero   = (bus.opcode == OP_ORI);
                state_d        = S_IWB;
            end

            S_IWB: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.ALUControl = imm_alu(bus.opcode);
                bus.ext_zero   = (bus.opcode == OP_ORI);
                bus.RegWrite   = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end

            S_JUMP: begin
                bus.PCSrc      = 2'b10;
                bus.pc_en      = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = S_FETCH;
            end

            // Unused encodings recover to FETCH.
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller with WAIT_LIMIT = 4. Inputs change
// 2 time units after the rising edge, outputs are checked 1 unit later.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   cyc;
    int   done_cnt;
    int   start_cyc;
    int   start_done;

    multicycle_controller_if bus ();

    multicycle_controller #(.WAIT_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // retirement pulse counter, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.instr_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        cyc      = 0;
        done_cnt = 0;
        rst      = 1'b1;
        bus.opcode    = 6'b000000;
        bus.funct     = 6'b000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        // ---------------- reset ----------------
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("rst_state", 8'(bus.state), 8'd0);
        check("rst_mem_req", 8'(bus.mem_req), 8'd1);
        check("rst_irwrite", 8'(bus.IRWrite), 8'd0);
        check("rst_pc_en", 8'(bus.pc_en), 8'd0);
        check("rst_done", 8'(bus.instr_done), 8'd0);
        check("rst_aluctl", 8'(bus.ALUControl), 8'h2);
        check("rst_alusrcb", 8'(bus.ALUSrcB), 8'h1);

        // ---------------- ADDU, zero wait ----------------
        bus.opcode = 6'b000000; bus.funct = 6'b100001; bus.mem_ready = 1'b1;
        start_cyc = cyc; start_done = done_cnt;
        settle();
        check("addu_f_irwrite", 8'(bus.IRWrite), 8'd1);
        check("addu_f_pc_en", 8'(bus.pc_en), 8'd1);
        tick(); settle();
        check("addu_st1", 8'(bus.state), 8'd1);
        check("addu_dec_srcb", 8'(bus.ALUSrcB), 8'h3);
        tick(); settle();
        check("addu_st6", 8'(bus.state), 8'd6);
        check("addu_ex_srca", 8'(bus.ALUSrcA), 8'd1);
        check("addu_ex_srcb", 8'(bus.ALUSrcB), 8'h0);
        check("addu_ex_alu", 8'(bus.ALUControl), 8'h2);
        tick(); settle();
        check("addu_st7", 8'(bus.state), 8'd7);
        check("addu_wb_regwrite", 8'(bus.RegWrite), 8'd1);
        check("addu_wb_regdst", 8'(bus.RegDst), 8'd1);
        check("addu_wb_done", 8'(bus.instr_done), 8'd1);
        tick(); settle();
        check("addu_back", 8'(bus.state), 8'd0);
        check("addu_cpi", 8'(cyc - start_cyc), 8'd4);
        check("addu_done_once", 8'(done_cnt - start_done), 8'd1);

        // ---------------- SUB ALU op ----------------
        bus.funct = 6'b100010;
        tick(); tick(); settle();
        check("sub_ex_alu", 8'(bus.ALUControl), 8'h6);
        tick(); settle();
        check("sub_wb_alu", 8'(bus.ALUControl), 8'h6);
        tick();

        // ---------------- LW with 3 wait cycles in MEMRD ----------------
        bus.opcode = 6'b100011; bus.mem_ready = 1'b1;
        start_cyc = cyc;
        tick(); settle();
        check("lw_st1", 8'(bus.state), 8'd1);
        tick(); settle();
        check("lw_st2", 8'(bus.state), 8'd2);
        check("lw_adr_srca", 8'(bus.ALUSrcA), 8'd1);
        check("lw_adr_srcb", 8'(bus.ALUSrcB), 8'h2);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check("lw_rd_wait_state", 8'(bus.state), 8'd3);
            check("lw_rd_wait_iord", 8'(bus.IorD), 8'd1);
            check("lw_rd_wait_req", 8'(bus.mem_req), 8'd1);
            check("lw_rd_wait_berr", 8'(bus.bus_error), 8'd0);
        end
        tick();
        bus.mem_ready = 1'b1;
        settle();
        check("lw_rd_last_state", 8'(bus.state), 8'd3);
        tick(); settle();
        check("lw_st4", 8'(bus.state), 8'd4);
        check("lw_wb_memtoreg", 8'(bus.MemtoReg), 8'd1);
        check("lw_wb_regwrite", 8'(bus.RegWrite), 8'd1);
        check("lw_wb_regdst", 8'(bus.RegDst), 8'd0);
        check("lw_wb_done", 8'(bus.instr_done), 8'd1);
        tick(); settle();
        check("lw_back", 8'(bus.state), 8'd0);
        check("lw_cpi", 8'(cyc - start_cyc), 8'd8);

        // ---------------- SW zero wait ----------------
        bus.opcode = 6'b101011;
        start_cyc = cyc;
        tick(); tick(); tick(); settle();
        check("sw_st5", 8'(bus.state), 8'd5);
        check("sw_memwrite", 8'(bus.MemWrite), 8'd1);
        check("sw_iord", 8'(bus.IorD), 8'd1);
        check("sw_done", 8'(bus.instr_done), 8'd1);
        tick(); settle();
        check("sw_cpi", 8'(cyc - start_cyc), 8'd4);

        // ---------------- BEQ taken / not taken ----------------
        bus.opcode = 6'b000100; bus.zero = 1'b1;
        start_cyc = cyc;
        tick(); tick(); settle();
        check("beq1_st8", 8'(bus.state), 8'd8);
        check("beq1_pc_en", 8'(bus.pc_en), 8'd1);
        check("beq1_pcsrc", 8'(bus.PCSrc), 8'h1);
        check("beq1_alu", 8'(bus.ALUControl), 8'h6);
        check("beq1_done", 8'(bus.instr_done), 8'd1);
        tick(); settle();
        check("beq1_cpi", 8'(cyc - start_cyc), 8'd3);
        bus.zero = 1'b0;
        start_cyc = cyc;
        tick(); tick(); settle();
        check("beq0_st8", 8'(bus.state), 8'd8);
        check("beq0_pc_en", 8'(bus.pc_en), 8'd0);
        tick(); settle();
        check("beq0_cpi", 8'(cyc - start_cyc), 8'd3);

        // ---------------- ORI and LUI ----------------
        bus.opcode = 6'b001101;
        tick(); tick(); settle();
        check("ori_st9", 8'(bus.state), 8'd9);
        check("ori_ext_zero", 8'(bus.ext_zero), 8'd1);
        check("ori_alu", 8'(bus.ALUControl), 8'h1);
        check("ori_srcb", 8'(bus.ALUSrcB), 8'h2);
        tick(); settle();
        check("ori_st10", 8'(bus.state), 8'd10);
        check("ori_wb_regwrite", 8'(bus.RegWrite), 8'd1);
        check("ori_wb_regdst", 8'(bus.RegDst), 8'd0);
        check("ori_wb_alu", 8'(bus.ALUControl), 8'h1);
        tick();
        bus.opcode = 6'b001111;
        tick(); tick(); settle();
        check("lui_alu", 8'(bus.ALUControl), 8'h3);
        check("lui_ext_zero", 8'(bus.ext_zero), 8'd0);
        tick(); tick();

        // ---------------- J ----------------
        bus.opcode = 6'b000010;
        start_cyc = cyc;
        tick(); tick(); settle();
        check("j_st11", 8'(bus.state), 8'd11);
        check("j_pcsrc", 8'(bus.PCSrc), 8'h2);
        check("j_pc_en", 8'(bus.pc_en), 8'd1);
        tick(); settle();
        check("j_cpi", 8'(cyc - start_cyc), 8'd3);

        // ---------------- illegal opcode / funct ----------------
        bus.opcode = 6'b111111;
        tick(); settle();
        check("ill_op_illegal", 8'(bus.illegal), 8'd1);
        check("ill_op_regwrite", 8'(bus.RegWrite), 8'd0);
        check("ill_op_memwrite", 8'(bus.MemWrite), 8'd0);
        tick(); settle();
        check("ill_op_back", 8'(bus.state), 8'd0);
        bus.opcode = 6'b000000; bus.funct = 6'b000111;
        tick(); settle();
        check("ill_fn_dec_ok", 8'(bus.illegal), 8'd0);
        tick(); settle();
        check("ill_fn_st6", 8'(bus.state), 8'd6);
        check("ill_fn_illegal", 8'(bus.illegal), 8'd1);
        tick(); settle();
        check("ill_fn_back", 8'(bus.state), 8'd0);

        // ---------------- reset in the middle of a MEMRD wait ----------------
        bus.opcode = 6'b100011; bus.funct = 6'b000000;
        tick(); tick();
        bus.mem_ready = 1'b0;
        tick(); tick(); settle();
        check("rstw_in_memrd", 8'(bus.state), 8'd3);
        rst = 1'b1;
        tick(); settle();
        check("rstw_state", 8'(bus.state), 8'd0);
        check("rstw_mem_req", 8'(bus.mem_req), 8'd1);
        check("rstw_iord", 8'(bus.IorD), 8'd0);
        check("rstw_regwrite", 8'(bus.RegWrite), 8'd0);
        rst = 1'b0;

        // ---------------- FETCH wait limit ----------------
        for (int i = 0; i < 4; i++) begin
            settle();
            check("to1_no_berr", 8'(bus.bus_error), 8'd0);
            tick();
        end
        settle();
        check("to1_berr", 8'(bus.bus_error), 8'd1);
        check("to1_irwrite", 8'(bus.IRWrite), 8'd0);
        check("to1_pc_en", 8'(bus.pc_en), 8'd0);
        check("to1_mem_req", 8'(bus.mem_req), 8'd1);
        tick(); settle();
        check("to1_refetch", 8'(bus.state), 8'd0);
        // counter must restart from zero: four quiet cycles again
        for (int i = 0; i < 4; i++) begin
            settle();
            check("to2_no_berr", 8'(bus.bus_error), 8'd0);
            check("to2_irwrite", 8'(bus.IRWrite), 8'd0);
            tick();
        end
        // mem_ready in the limit cycle completes normally
        bus.mem_ready = 1'b1;
        bus.opcode = 6'b101011;
        settle();
        check("to2_ready_wins_berr", 8'(bus.bus_error), 8'd0);
        check("to2_ready_wins_irw", 8'(bus.IRWrite), 8'd1);
        tick(); settle();
        check("to2_decode", 8'(bus.state), 8'd1);

        // ---------------- MEMWR wait limit ----------------
        tick();
        bus.mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            settle();
            check("tow_memwrite", 8'(bus.MemWrite), 8'd1);
            check("tow_no_berr", 8'(bus.bus_error), 8'd0);
            tick();
        end
        settle();
        check("tow_state", 8'(bus.state), 8'd5);
        check("tow_berr", 8'(bus.bus_error), 8'd1);
        check("tow_memwrite_off", 8'(bus.MemWrite), 8'd0);
        check("tow_no_done", 8'(bus.instr_done), 8'd0);
        tick(); settle();
        check("tow_refetch", 8'(bus.state), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
